regfile_param: RTL
==================

// Module: regfile_param
// PURPOSE
//   Parametrised general-purpose register file for the MIPS datapath: two registered read
//   ports and one write port. Configurable width and depth, optional hardwired-zero entry
//   and optional write-to-read bypass. Includes a sequential clear engine that zeroes the
//   array one entry per cycle. Sits between decode (read addresses) and writeback.
// PARAMETERS
//   DATA_W    32  data width of each register
//   ADDR_W    5   address width; NUM_REGS = 2**ADDR_W entries
//   ZERO_REG  1   1: entry 0 always reads 0, writes to it are discarded
//   BYPASS    1   1: same-cycle write forwarded to read port; 0: read returns old value
// PORTS
//   Clk         in   1       clock, all state on rising edge
//   Reset_n     in   1       asynchronous active-low reset
//   Read_reg1   in   ADDR_W  read address, port 1
//   Read_reg2   in   ADDR_W  read address, port 2
//   Reg_write   in   1       write enable
//   Write_reg   in   ADDR_W  write address
//   Write_data  in   DATA_W  write data
//   Clear       in   1       start array clear (single-cycle pulse, level ignored while Busy)
//   Read_data1  out  DATA_W  registered read data, port 1
//   Read_data2  out  DATA_W  registered read data, port 2
//   Busy        out  1       clear sweep in progress
//   Wr_drop     out  1       1-cycle pulse: a requested write was discarded
// BEHAVIOUR
//   Reset (Reset_n=0, async): every array entry 0, Read_data1/2=0, Busy=0, Wr_drop=0, FSM IDLE,
//     sweep counter 0. Deassertion takes effect on next rising Clk.
//   Read: Read_dataN <= array[Read_regN] at each rising edge; latency 1 cycle, no enable.
//     ZERO_REG=1 and Read_regN==0 -> 0 regardless of array contents.
//     BYPASS=1, Reg_write=1, Write_reg==Read_regN, write accepted -> Read_dataN <= Write_data.
//     BYPASS=0 same case -> Read_dataN <= old entry value; new value visible next cycle.
//   Write: accepted when Reg_write=1, FSM IDLE, Clear=0, and !(ZERO_REG && Write_reg==0);
//     array[Write_reg] <= Write_data on the rising edge. No intra-cycle delays.
//   Wr_drop <= 1 for one cycle when Reg_write=1 and write not accepted due to Busy or Clear
//     (write to entry 0 with ZERO_REG=1 is silent, Wr_drop stays 0).
//   FSM IDLE: Clear=1 -> CLEAR, counter <= 0, Busy <= 1. Clear wins over a same-cycle write.
//   FSM CLEAR: array[counter] <= 0, counter += 1 each cycle; after entry NUM_REGS-1 is
//     zeroed -> IDLE, Busy <= 0 on that same edge. Sweep = NUM_REGS cycles exactly.
//     Clear asserted during CLEAR ignored (no restart). Counter width ADDR_W, wraps to 0.
//   Reads while Busy=1 or on the Clear cycle: Read_data1/2 <= 0 (no partial-clear data exposed).
//   Reset mid-sweep: immediate abort, all state to reset values, array fully zero.
//   Both read ports may address the same entry; each independently applies the rules above.
// TESTING
//   Reset, write r5=0xDEADBEEF, next cycle read r5 on both ports -> Read_data1=Read_data2=0xDEADBEEF after 1 clk.
//   Write r0=0x12345678 (ZERO_REG=1), read r0 -> 0, Wr_drop=0.
//   Same-cycle write r7=0xA5A5A5A5 and read r7, prior value 0x1 -> BYPASS=1: 0xA5A5A5A5; BYPASS=0: 0x1, then 0xA5A5A5A5.
//   Fill r1..r31 with index, pulse Clear -> Busy high exactly 32 cycles, reads 0 during sweep, all entries 0 after.
//   Reg_write=1 with Clear=1, then again during Busy -> Wr_drop pulses each time, target entry reads 0 after sweep.
//   Assert Reset_n=0 at sweep cycle 10 between edges -> Busy=0, Read_data=0 immediately; r3 write afterwards reads back.

Source files
------------

// File: rtl/regfile_param.sv
// Two-read/one-write register file with registered reads, optional hardwired-zero
// entry, optional write-to-read bypass and a one-entry-per-cycle clear sweep.
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [ADDR_W-1:0] Read_reg1,
  input  logic [ADDR_W-1:0] Read_reg2,
  input  logic              Reg_write,
  input  logic [ADDR_W-1:0] Write_reg,
  input  logic [DATA_W-1:0] Write_data,
  input  logic              Clear,
  output logic [DATA_W-1:0] Read_data1,
  output logic [DATA_W-1:0] Read_data2,
  output logic              Busy,
  output logic              Wr_drop
);

  localparam int NUM_REGS = 2**ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] mem_d [NUM_REGS];
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic              busy_q, busy_d;
  logic              wr_drop_q, wr_drop_d;

  logic wr_zero;
  logic start_clr;
  logic wr_ok;
  logic blank;

  always_comb begin
    wr_zero   = (ZERO_REG != 0) && (Write_reg == '0);
    start_clr = (state_q == IDLE) && Clear;
    wr_ok     = Reg_write && (state_q == IDLE) && !Clear && !wr_zero;
    // Sweep in progress or just starting: never expose partially cleared data.
    blank     = (state_q == CLEAR) || start_clr;
    wr_drop_d = Reg_write && !wr_zero && ((state_q == CLEAR) || Clear);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    mem_d   = mem_q;
    case (state_q)
      IDLE: begin
        if (Clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else if (wr_ok) begin
          mem_d[Write_reg] = Write_data;
        end
      end
      CLEAR: begin
        mem_d[cnt_q] = '0;
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(NUM_REGS - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd1_d = mem_q[Read_reg1];
    if (blank || ((ZERO_REG != 0) && (Read_reg1 == '0)))
      rd1_d = '0;
    else if ((BYPASS != 0) && wr_ok && (Write_reg == Read_reg1))
      rd1_d = Write_data;

    rd2_d = mem_q[Read_reg2];
    if (blank || ((ZERO_REG != 0) && (Read_reg2 == '0)))
      rd2_d = '0;
    else if ((BYPASS != 0) && wr_ok && (Write_reg == Read_reg2))
      rd2_d = Write_data;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      wr_drop_q <= 1'b0;
      rd1_q     <= '0;
      rd2_q     <= '0;
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      wr_drop_q <= wr_drop_d;
      rd1_q     <= rd1_d;
      rd2_q     <= rd2_d;
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign Read_data1 = rd1_q;
  assign Read_data2 = rd2_q;
  assign Busy       = busy_q;
  assign Wr_drop    = wr_drop_q;

endmodule
